image_downscaler: RTL
=====================

Name: image_downscaler

Overview:
- Consumes a raster pixel stream at full display resolution (default 640x480) over a valid/ready interface.
- Produces a box-averaged, reduced-resolution stream (default 80x60) over a valid/ready interface.
- Each output pixel is the truncated mean of one scale_x x scale_y block of input pixels.
- Sits at the opposite end of the image_scaler path: it reduces display-resolution frames back to sensor resolution for thumbnailing and loopback checks.

Parameters:
pixel_width_p, 16, bits per pixel on input and output
input_width_p, 640, input pixels per line
input_height_p, 480, input lines per frame
output_width_p, 80, output pixels per line
output_height_p, 60, output lines per frame
scale_x_p, input_width_p/output_width_p (derived, 8), horizontal block size; must be a power of 2 and >= 2
scale_y_p, input_height_p/output_height_p (derived, 8), vertical block size; must be a power of 2 and >= 2

Ports:
clk_i  input  1  clock; all logic on its rising edge
reset_i  input  1  synchronous, active-high reset
pixel_i  input  pixel_width_p  input pixel, raster order
valid_i  input  1  pixel_i is valid
ready_o  output  1  block can accept pixel_i this cycle
pixel_o  output  pixel_width_p  averaged output pixel, raster order
valid_o  output  1  pixel_o is valid
ready_i  input  1  downstream accepts pixel_o this cycle
frame_done_o  output  1  one-cycle pulse when the last output pixel of a frame is accepted

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous, active-high, on reset_i.
- Reset values:
  - valid_o=0, frame_done_o=0, pixel_o=0.
  - Input counters in_x=0, in_y=0; output counters out_x=0, out_y=0.
  - Accumulator memory is not reset.
- Handshakes:
  - Input transfer when valid_i && ready_o.
  - Output transfer when valid_o && ready_i.
  - ready_o = !(valid_o && !ready_i), combinational. Input is accepted whenever the output register is empty or is being drained this cycle.
  - ready_o is independent of valid_i.
- Counters:
  - in_x runs 0..input_width_p-1. On wrap, in_y increments.
  - in_y wraps to 0 after input_height_p-1, with no idle gap between frames.
  - sub_x = in_x[log2(scale_x_p)-1:0], sub_y = in_y[log2(scale_y_p)-1:0], blk = in_x >> log2(scale_x_p).
- Accumulation:
  - Accumulator width: acc_w = pixel_width_p + log2(scale_x_p*scale_y_p), 22 by default.
  - One accumulator per output column: output_width_p entries of acc_w bits.
  - On each input transfer:
    - sub_x==0 && sub_y==0: acc[blk] <= zero-extended pixel_i (fresh start; no clear pass needed).
    - Otherwise: acc[blk] <= acc[blk] + pixel_i.
    - sub_x==scale_x_p-1 && sub_y==scale_y_p-1: output register loads (acc[blk] + pixel_i) >> log2(scale_x_p*scale_y_p), and valid_o <= 1 on the next cycle.
  - Division truncates (floor); no rounding.
  - Accumulators never overflow. All-max input yields all-max output.
- Latency: valid_o rises the cycle after the transfer of the final pixel of a block.
- Holding output: while valid_o && !ready_i, pixel_o is held stable and no input is accepted.
- Simultaneous drain and load: if the output drains in the same cycle a new block completes, the new value loads and valid_o stays 1.
- Output counters:
  - out_x/out_y advance on each output transfer in raster order.
  - out_x wraps at output_width_p-1. out_y wraps at output_height_p-1 back to 0.
  - frame_done_o pulses on the transfer with out_x==output_width_p-1 && out_y==output_height_p-1.
- Reset mid-frame: all counters return to 0 and any pending output is dropped. The next accepted pixel is treated as pixel (0,0) of a new frame.
- No sideband start-of-frame; alignment is by count from reset only.

Test Plan:
- Constant frame: all 307200 input pixels 0x1234 -> exactly 4800 outputs, all 0x1234, and frame_done_o pulses once on the 4800th transfer.
- Horizontal ramp: pixel_i = in_x -> output column k equals 8k+3 on every line (floor of 8k+3.5), e.g. k=0 gives 3, k=79 gives 635.
- Saturation: all inputs 0xFFFF -> all outputs 0xFFFF (no accumulator wrap). Alternating 0xFFFF/0x0000 by column -> 0x7FFF.
- Backpressure: hold ready_i=0 for 20 cycles after valid_o rises, with valid_i=1 throughout -> ready_o=0 for those cycles, pixel_o unchanged, and no input or output pixel lost or duplicated (output sequence matches the golden model).
- Random valid_i/ready_i at 50% duty over two back-to-back frames of random data -> output matches the reference box average bit-exactly, and frame_done_o pulses exactly twice.
- Reset after 1000 accepted pixels, then a full constant-0x0042 frame -> the first output is 0x0042 and exactly 4800 outputs follow.

Source files
------------

// File: rtl/image_downscaler.sv
// Box-average downscaler: each output pixel is the floor mean of one
// scale_x_p x scale_y_p block of the raster input stream.
module image_downscaler #(
  parameter int pixel_width_p   = 16,
  parameter int input_width_p   = 640,
  parameter int input_height_p  = 480,
  parameter int output_width_p  = 80,
  parameter int output_height_p = 60,
  parameter int scale_x_p       = input_width_p / output_width_p,
  parameter int scale_y_p       = input_height_p / output_height_p
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [pixel_width_p-1:0] pixel_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [pixel_width_p-1:0] pixel_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     frame_done_o
);

  localparam int LX  = $clog2(scale_x_p);
  localparam int LY  = $clog2(scale_y_p);
  localparam int ACW = pixel_width_p + LX + LY;
  localparam int XW  = $clog2(input_width_p);
  localparam int YW  = $clog2(input_height_p);
  localparam int BW  = XW - LX;
  localparam int OXW = (output_width_p > 1) ? $clog2(output_width_p) : 1;
  localparam int OYW = (output_height_p > 1) ? $clog2(output_height_p) : 1;

  logic [XW-1:0]            r_in_x;
  logic [YW-1:0]            r_in_y;
  logic [OXW-1:0]           r_out_x;
  logic [OYW-1:0]           r_out_y;
  logic [ACW-1:0]           r_acc [output_width_p];
  logic [pixel_width_p-1:0] r_pix;
  logic                     r_valid;

  logic           w_ready;
  logic           w_in_xfer;
  logic           w_out_xfer;
  logic           w_first;
  logic           w_last;
  logic           w_x_end;
  logic           w_y_end;
  logic           w_ox_end;
  logic           w_oy_end;
  logic [BW-1:0]  w_blk;
  logic [ACW-1:0] w_base;
  logic [ACW-1:0] w_sum;

  assign w_ready    = !(r_valid && !ready_i);
  assign w_in_xfer  = valid_i && w_ready;
  assign w_out_xfer = r_valid && ready_i;

  assign w_blk   = r_in_x[XW-1:LX];
  assign w_first = (r_in_x[LX-1:0] == '0) && (r_in_y[LY-1:0] == '0);
  assign w_last  = (&r_in_x[LX-1:0]) && (&r_in_y[LY-1:0]);
  assign w_x_end = (r_in_x == XW'(input_width_p - 1));
  assign w_y_end = (r_in_y == YW'(input_height_p - 1));

  assign w_ox_end = (r_out_x == OXW'(output_width_p - 1));
  assign w_oy_end = (r_out_y == OYW'(output_height_p - 1));

  // First pixel of a block overwrites, so the column RAM never needs clearing.
  assign w_base = w_first ? '0 : r_acc[w_blk];
  assign w_sum  = w_base + ACW'(pixel_i);

  assign ready_o      = w_ready;
  assign valid_o      = r_valid;
  assign pixel_o      = r_pix;
  assign frame_done_o = w_out_xfer && w_ox_end && w_oy_end;

  always_ff @(posedge clk_i) begin
    if (!reset_i && w_in_xfer) begin
      r_acc[w_blk] <= w_sum;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_in_x  <= '0;
      r_in_y  <= '0;
      r_out_x <= '0;
      r_out_y <= '0;
      r_valid <= 1'b0;
      r_pix   <= '0;
    end else begin
      if (w_in_xfer) begin
        if (w_x_end) begin
          r_in_x <= '0;
          r_in_y <= w_y_end ? '0 : r_in_y + YW'(1);
        end else begin
          r_in_x <= r_in_x + XW'(1);
        end
      end
      if (w_out_xfer) begin
        if (w_ox_end) begin
          r_out_x <= '0;
          r_out_y <= w_oy_end ? '0 : r_out_y + OYW'(1);
        end else begin
          r_out_x <= r_out_x + OXW'(1);
        end
      end
      if (w_in_xfer && w_last) begin
        r_valid <= 1'b1;
        r_pix   <= w_sum[ACW-1:LX+LY];
      end else if (w_out_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule
